// File: rtl/dac_pkg.sv
// Shared encodings for the DAC waveform generator: waveform modes and
// serial frame states.
package dac_pkg;

    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_SAW    = 2'b01;
    localparam logic [1:0] MODE_TRI    = 2'b10;
    localparam logic [1:0] MODE_SQUARE = 2'b11;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CS_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT    = 3'd2;
    localparam logic [2:0] ST_CS_HOLD  = 3'd3;
    localparam logic [2:0] ST_LOAD     = 3'd4;

endpackage

// File: rtl/dac_spi_tx.sv
// Serial DAC frame transmitter: captures a shadow code on start and shifts it
// out MSB first, framed by cs and followed by an ldac pulse.
module dac_spi_tx
    import dac_pkg::*;
#(
    parameter int DAC_BITS  = 12,
    parameter int HALF_CLKS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [DAC_BITS-1:0] data,
    output logic                busy,
    output logic                cs,
    output logic                sclk,
    output logic                sdin,
    output logic                ldac
);

    localparam int HW = $clog2(HALF_CLKS + 1);
    localparam int BW = $clog2(DAC_BITS + 1);
    localparam logic [HW-1:0] HCNT_MAX = HW'(HALF_CLKS - 1);
    localparam logic [BW-1:0] BIT_MAX  = BW'(DAC_BITS - 1);

    logic [2:0]          state_r;
    logic [HW-1:0]       hcnt_r;
    logic [BW-1:0]       bit_r;
    logic [DAC_BITS-1:0] shift_r;
    logic                busy_r;
    logic                cs_r;
    logic                sclk_r;
    logic                ldac_r;
    logic                hcnt_last_s;

    assign hcnt_last_s = (hcnt_r == HCNT_MAX);

    // Frame sequencer; sdin is taken straight from the shift register MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            hcnt_r  <= '0;
            bit_r   <= '0;
            shift_r <= '0;
            busy_r  <= 1'b0;
            cs_r    <= 1'b1;
            sclk_r  <= 1'b0;
            ldac_r  <= 1'b1;
        end else begin
            if (state_r == ST_IDLE) begin
                hcnt_r <= '0;
            end else begin
                hcnt_r <= hcnt_last_s ? '0 : hcnt_r + 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_CS_SETUP;
                        shift_r <= data;
                        bit_r   <= '0;
                        busy_r  <= 1'b1;
                        cs_r    <= 1'b0;
                    end
                end
                ST_CS_SETUP: begin
                    if (hcnt_last_s) begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (hcnt_last_s) begin
                        if (!sclk_r) begin
                            sclk_r <= 1'b1;
                        end else begin
                            // Falling sclk edge: advance to the next bit.
                            sclk_r <= 1'b0;
                            if (bit_r == BIT_MAX) begin
                                state_r <= ST_CS_HOLD;
                            end else begin
                                bit_r   <= bit_r + 1'b1;
                                shift_r <= {shift_r[DAC_BITS-2:0], 1'b0};
                            end
                        end
                    end
                end
                ST_CS_HOLD: begin
                    if (hcnt_last_s) begin
                        state_r <= ST_LOAD;
                        shift_r <= '0;
                        cs_r    <= 1'b1;
                        ldac_r  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (hcnt_last_s) begin
                        state_r <= ST_IDLE;
                        ldac_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    shift_r <= '0;
                    busy_r  <= 1'b0;
                    cs_r    <= 1'b1;
                    sclk_r  <= 1'b0;
                    ldac_r  <= 1'b1;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign cs   = cs_r;
    assign sclk = sclk_r;
    assign sdin = shift_r[DAC_BITS-1];
    assign ldac = ldac_r;

endmodule

// File: rtl/dac_wavegen.sv
// DAC waveform generator: rate ticker, waveform code stepping and a single
// pending-frame queue in front of the serial transmitter.
module dac_wavegen
    import dac_pkg::*;
#(
    parameter int DAC_BITS  = 12,
    parameter int HALF_CLKS = 4,
    parameter int RATE_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           mode,
    input  logic [RATE_BITS-1:0] period,
    input  logic [DAC_BITS-1:0]  static_val,
    input  logic                 enable,
    output logic [DAC_BITS-1:0]  dac,
    output logic                 busy,
    output logic                 overrun,
    output logic                 cs,
    output logic                 sclk,
    output logic                 sdin,
    output logic                 ldac
);

    localparam logic [DAC_BITS-1:0] CODE_MAX = '1;

    logic [RATE_BITS-1:0] cnt_r;
    logic [DAC_BITS-1:0]  dac_r;
    logic [1:0]           mode_r;
    logic                 tri_up_r;
    logic                 pending_r;
    logic                 overrun_r;
    logic                 tick_s;
    logic                 mode_chg_s;
    logic                 tri_up_eff_s;
    logic                 tri_up_next_s;
    logic [DAC_BITS-1:0]  next_code_s;
    logic                 start_s;
    logic [DAC_BITS-1:0]  start_data_s;
    logic                 tx_busy_s;

    assign tick_s       = enable && (cnt_r == period);
    assign mode_chg_s   = (mode != mode_r);
    assign tri_up_eff_s = mode_chg_s ? 1'b1 : tri_up_r;
    assign start_s      = tx_busy_s ? 1'b0 : (tick_s | pending_r);
    assign start_data_s = tick_s ? next_code_s : dac_r;

    // Next waveform code, applied only on a tick.
    always_comb begin
        next_code_s   = dac_r;
        tri_up_next_s = tri_up_eff_s;
        case (mode)
            MODE_STATIC: next_code_s = static_val;
            MODE_SAW:    next_code_s = dac_r + 1'b1;
            MODE_TRI: begin
                if (tri_up_eff_s) begin
                    if (dac_r == CODE_MAX) begin
                        next_code_s   = dac_r - 1'b1;
                        tri_up_next_s = 1'b0;
                    end else begin
                        next_code_s   = dac_r + 1'b1;
                    end
                end else begin
                    if (dac_r == '0) begin
                        next_code_s   = dac_r + 1'b1;
                        tri_up_next_s = 1'b1;
                    end else begin
                        next_code_s   = dac_r - 1'b1;
                    end
                end
            end
            MODE_SQUARE: next_code_s = (dac_r == '0) ? static_val : '0;
            default:     next_code_s = dac_r;
        endcase
    end

    // Rate counter, waveform state and frame queueing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= '0;
            dac_r     <= '0;
            mode_r    <= MODE_STATIC;
            tri_up_r  <= 1'b1;
            pending_r <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (!enable || tick_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + 1'b1;
            end
            mode_r <= mode;
            if (tick_s) begin
                dac_r    <= next_code_s;
                tri_up_r <= tri_up_next_s;
            end else if (mode_chg_s) begin
                tri_up_r <= 1'b1;
            end
            // A second queued tick only sets overrun; the newest dac is sent.
            if (start_s) begin
                pending_r <= 1'b0;
            end else if (tick_s && tx_busy_s) begin
                pending_r <= 1'b1;
                if (pending_r) begin
                    overrun_r <= 1'b1;
                end
            end
        end
    end

    dac_spi_tx #(
        .DAC_BITS  (DAC_BITS),
        .HALF_CLKS (HALF_CLKS)
    ) u_spi_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_s),
        .data  (start_data_s),
        .busy  (tx_busy_s),
        .cs    (cs),
        .sclk  (sclk),
        .sdin  (sdin),
        .ldac  (ldac)
    );

    assign dac     = dac_r;
    assign busy    = tx_busy_s;
    assign overrun = overrun_r;

endmodule

// File: doc/dac_wavegen.md
DAC_WAVEGEN -- requirements
Module: dac_wavegen

Interface
REQ-001 Parameter DAC_BITS, default 12, SHALL set the DAC code width.
REQ-002 Parameter HALF_CLKS, default 4, SHALL set the clk cycles per sclk half-period (minimum 2).
REQ-003 Parameter RATE_BITS, default 24, SHALL set the width of the update-period input.
REQ-004 Port clk, input, 1: 100 MHz system clock.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port mode, input, 2: 00 static, 01 sawtooth, 10 triangle, 11 square.
REQ-007 Port period, input, RATE_BITS: clk cycles between updates, minus one.
REQ-008 Port static_val, input, DAC_BITS: the code loaded in static mode and used as the square high level.
REQ-009 Port enable, input, 1: enables update ticks.
REQ-010 Port dac, output, DAC_BITS: the code most recently latched for transmit.
REQ-011 Port busy, output, 1: high while a serial frame is in progress.
REQ-012 Port overrun, output, 1: sticky flag, set when a tick arrives while one tick is already pending.
REQ-013 Ports cs, sclk, sdin, ldac, output, 1 each: the DAC serial pins; cs and ldac are active low.

Function
REQ-014 The rate counter SHALL count 0..period and raise a one-cycle tick on reaching period, then wrap to 0; when enable=0, the counter SHALL hold at 0.
REQ-015 On each tick, the next code SHALL be computed and latched into dac in the same cycle:
- static: static_val.
- sawtooth: dac+1, wrapping from max to 0.
- triangle: dac+1 while rising and dac-1 while falling; direction reverses at max and at 0, with no repeated endpoint.
- square: toggles between 0 and static_val.
REQ-016 A mode change SHALL take effect at the next tick, starting from the current dac value; the triangle direction SHALL reset to rising on any mode change.
REQ-017 A tick while idle SHALL start a frame on the next cycle.
REQ-018 A tick while busy SHALL set a single pending flag; that frame SHALL start in the cycle after the current frame returns to IDLE.
REQ-019 A tick while busy with pending already set SHALL set overrun, and the newest dac value SHALL be the one sent.
REQ-020 The frame state machine SHALL run IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> LOAD -> IDLE. CS_SETUP, CS_HOLD and LOAD SHALL each last HALF_CLKS cycles.
REQ-021 In CS_SETUP, cs SHALL be low and sclk low.
REQ-022 In SHIFT, the latched code SHALL be sent MSB first, DAC_BITS sclk periods long; sdin SHALL change on the sclk falling edge and be stable for the rising edge.
REQ-023 In CS_HOLD, cs SHALL be low and sclk low.
REQ-024 In LOAD, cs SHALL be high and ldac low.
REQ-025 The frame length SHALL be (2*DAC_BITS+3)*HALF_CLKS cycles; busy SHALL be high for exactly those cycles.
REQ-026 The frame SHALL transmit a shadow copy of dac captured at frame start; dac changes during a frame SHALL NOT affect that frame.

Reset
REQ-027 While rst_n=0, the outputs SHALL be: dac=0, busy=0, overrun=0, cs=1, sclk=0, sdin=0, ldac=1.
REQ-028 While rst_n=0, the counters, pending flag, triangle direction and state (IDLE) SHALL be cleared.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately, with cs returning to 1 and no ldac pulse.
REQ-030 overrun SHALL clear only on reset.

Structure
REQ-031 The mode encodings and the frame state enumeration SHALL reside in the shared package dac_pkg.
REQ-032 The serial framing (REQ-020 to REQ-026) SHALL be a sub-module dac_spi_tx with a start/busy handshake; dac_wavegen SHALL hold the rate, waveform and pending logic.

Verification
REQ-033 Static: mode=00, static_val=0xA5C, period=99 -> after reset, frames at 100-cycle spacing; sdin bits across SHIFT are 1010_0101_1100; ldac low for 4 cycles after cs rises.
REQ-034 Sawtooth wrap: DAC_BITS=4, mode=01, period=199 -> dac sequence 1..15, 0, 1; each frame lasts 44 cycles.
REQ-035 Triangle: DAC_BITS=3 -> dac sequence 1..7, 6..0, 1; 7 and 0 each appear once per turn.
REQ-036 Overrun: period=9, frame 108 cycles -> one pending frame queued, overrun=1 by the third tick within a frame; the transmitted code equals the latest dac.
REQ-037 Reset mid-SHIFT at bit 5 -> cs=1, ldac=1, busy=0 in the same cycle; after release, the first frame follows the first tick.
REQ-038 enable=0 for 500 cycles -> no frames, dac is held, and the counter restarts from 0 when enable returns to 1.
